// File: rtl/writeback_pkg.sv
// Shared encodings and helpers for the writeback stage and its register files.
package writeback_pkg;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  rw;
    logic [4:0]  rd;
  } ew_t;

  // A read port sees the pending commit when it addresses the same file and index.
  // GPR[0] is never forwarded since it is hardwired to zero.
  function automatic logic bypass_hit(input logic fresh, input ew_t ew, input logic [5:0] addr);
    logic file_match;
    file_match = addr[5] ? (ew.rw == RW_FPR) : (ew.rw == RW_GPR && ew.rd != 5'd0);
    return fresh && file_match && (addr[4:0] == ew.rd);
  endfunction

endpackage

// File: rtl/regfile32.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero entry 0 and one entry with a non-zero reset value.
module regfile32
  import writeback_pkg::*;
#(
  parameter bit          ZERO_R0  = 1'b0,
  parameter int          INIT_IDX = 0,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= (i == INIT_IDX) ? INIT_VAL : 32'h0;
      end
    end else if (we && !(ZERO_R0 && waddr == 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (ZERO_R0 && raddr_a == 5'd0) ? 32'h0 : mem[raddr_a];
  assign rdata_b = (ZERO_R0 && raddr_b == 5'd0) ? 32'h0 : mem[raddr_b];

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: E/W register, deferred commit to GPR/FPR, bypassed
// operand reads for decode and a retired-instruction counter.
module writeback
  import writeback_pkg::*;
#(
  parameter int          SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ex_d,
  input  logic [1:0]  ex_rw,
  input  logic [4:0]  ex_rd,
  input  logic        ex_valid,
  input  logic        stall,
  output logic [31:0] ew_d,
  output logic [1:0]  ew_rw,
  output logic [4:0]  ew_rd,
  input  logic [5:0]  rs_addr,
  input  logic [5:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] retired
);

  ew_t         ew_reg;
  logic        ew_fresh_reg;
  logic [31:0] retired_reg;
  logic        capture;

  assign capture = ex_valid && !stall;

  // ew_fresh marks a capture whose commit happens on the next edge; holding
  // ew_* through stalls keeps forwarding valid without committing twice.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ew_reg       <= '0;
      ew_fresh_reg <= 1'b0;
      retired_reg  <= 32'h0;
    end else begin
      ew_fresh_reg <= capture;
      if (capture) begin
        ew_reg      <= '{d: ex_d, rw: ex_rw, rd: ex_rd};
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  assign ew_d    = ew_reg.d;
  assign ew_rw   = ew_reg.rw;
  assign ew_rd   = ew_reg.rd;
  assign retired = retired_reg;

  logic        gpr_we, fpr_we;
  logic [31:0] gpr_rs, gpr_rt, fpr_rs, fpr_rt;

  assign gpr_we = ew_fresh_reg && (ew_reg.rw == RW_GPR);
  assign fpr_we = ew_fresh_reg && (ew_reg.rw == RW_FPR);

  regfile32 #(.ZERO_R0(1'b1), .INIT_IDX(SP_REG), .INIT_VAL(SP_INIT)) u_gpr (
    .clk(clk), .rstn(rstn), .we(gpr_we), .waddr(ew_reg.rd), .wdata(ew_reg.d),
    .raddr_a(rs_addr[4:0]), .raddr_b(rt_addr[4:0]), .rdata_a(gpr_rs), .rdata_b(gpr_rt)
  );

  regfile32 #(.ZERO_R0(1'b0), .INIT_IDX(0), .INIT_VAL(32'h0)) u_fpr (
    .clk(clk), .rstn(rstn), .we(fpr_we), .waddr(ew_reg.rd), .wdata(ew_reg.d),
    .raddr_a(rs_addr[4:0]), .raddr_b(rt_addr[4:0]), .rdata_a(fpr_rs), .rdata_b(fpr_rt)
  );

  assign rs_data = bypass_hit(ew_fresh_reg, ew_reg, rs_addr) ? ew_reg.d
                 : (rs_addr[5] ? fpr_rs : gpr_rs);
  assign rt_data = bypass_hit(ew_fresh_reg, ew_reg, rt_addr) ? ew_reg.d
                 : (rt_addr[5] ? fpr_rt : gpr_rt);

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: the driver pushes architecturally expected
// outputs per cycle, a monitor pops and compares them on the falling edge.
module tb_writeback;

  logic        clk;
  logic        rstn;
  logic [31:0] ex_d;
  logic [1:0]  ex_rw;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        stall;
  logic [31:0] ew_d;
  logic [1:0]  ew_rw;
  logic [4:0]  ew_rd;
  logic [5:0]  rs_addr;
  logic [5:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] retired;

  writeback #(.SP_REG(29), .SP_INIT(32'h0001_0000)) dut (
    .clk(clk), .rstn(rstn), .ex_d(ex_d), .ex_rw(ex_rw), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .stall(stall), .ew_d(ew_d), .ew_rw(ew_rw), .ew_rd(ew_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ew_d;
    logic [1:0]  ew_rw;
    logic [4:0]  ew_rd;
    logic [31:0] retired;
    logic [5:0]  rs_addr;
    logic [31:0] rs_data;
    logic [5:0]  rt_addr;
    logic [31:0] rt_data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Architectural model: a retired write is visible to readers immediately.
  logic [31:0] m_gpr [32];
  logic [31:0] m_fpr [32];
  logic [31:0] m_ew_d;
  logic [1:0]  m_ew_rw;
  logic [4:0]  m_ew_rd;
  logic [31:0] m_retired;
  bit          model_ok = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = 32'h0;
      m_fpr[i] = 32'h0;
    end
    m_gpr[29] = 32'h0001_0000;
    m_ew_d = 32'h0; m_ew_rw = 2'b00; m_ew_rd = 5'd0; m_retired = 32'h0;
    model_ok = 1;
  endfunction

  function automatic void model_retire(input logic [1:0] rw, input logic [4:0] rd, input logic [31:0] d);
    m_ew_d = d; m_ew_rw = rw; m_ew_rd = rd;
    m_retired = m_retired + 1;
    if (rw == 2'b01 && rd != 5'd0) m_gpr[rd] = d;
    if (rw == 2'b10) m_fpr[rd] = d;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (a[5]) return m_fpr[a[4:0]];
    if (a[4:0] == 5'd0) return 32'h0;
    return m_gpr[a[4:0]];
  endfunction

  task automatic step(input logic rn, input logic v, input logic s, input logic [1:0] rw,
                      input logic [4:0] rd, input logic [31:0] d,
                      input logic [5:0] rs, input logic [5:0] rt);
    exp_t e;
    rstn = rn; ex_valid = v; stall = s; ex_rw = rw; ex_rd = rd; ex_d = d;
    rs_addr = rs; rt_addr = rt;
    if (model_ok) begin
      e.ew_d = m_ew_d; e.ew_rw = m_ew_rw; e.ew_rd = m_ew_rd; e.retired = m_retired;
      e.rs_addr = rs; e.rs_data = model_read(rs);
      e.rt_addr = rt; e.rt_data = model_read(rt);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!rn) model_reset();
    else if (v && !s) model_retire(rw, rd, d);
    #1;
  endtask

  task automatic idle(input logic [5:0] rs, input logic [5:0] rt);
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, rs, rt);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are stable half a cycle after the driver changes inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ew_d", ew_d, e.ew_d);
        check("ew_rw", {30'h0, ew_rw}, {30'h0, e.ew_rw});
        check("ew_rd", {27'h0, ew_rd}, {27'h0, e.ew_rd});
        check("retired", retired, e.retired);
        check($sformatf("rs_data@%h", e.rs_addr), rs_data, e.rs_data);
        check($sformatf("rt_data@%h", e.rt_addr), rt_data, e.rt_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [4:0] rd;
    rstn = 1'b0; ex_valid = 1'b0; stall = 1'b0; ex_rw = 2'b00; ex_rd = 5'd0;
    ex_d = 32'h0; rs_addr = 6'h0; rt_addr = 6'h0;

    // Reset values, including the stack pointer initialisation
    step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 6'h1D, 6'h05);
    step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 6'h1D, 6'h05);
    idle(6'h1D, 6'h25);

    // GPR[5] write: bypass cycle, then array cycle
    step(1'b1, 1'b1, 1'b0, 2'b01, 5'd5, 32'h1234_5678, 6'h05, 6'h25);
    idle(6'h05, 6'h25);
    idle(6'h05, 6'h05);

    // GPR[0] is never written
    step(1'b1, 1'b1, 1'b0, 2'b01, 5'd0, 32'hFFFF_FFFF, 6'h00, 6'h20);
    idle(6'h00, 6'h20);
    idle(6'h00, 6'h00);

    // FPR[3] write does not alias GPR[3]
    step(1'b1, 1'b1, 1'b0, 2'b10, 5'd3, 32'h3F80_0000, 6'h03, 6'h23);
    idle(6'h03, 6'h23);
    idle(6'h03, 6'h23);

    // Stall blocks capture; release captures exactly once
    repeat (3) step(1'b1, 1'b1, 1'b1, 2'b01, 5'd9, 32'hAAAA_5555, 6'h09, 6'h05);
    step(1'b1, 1'b1, 1'b0, 2'b01, 5'd9, 32'hAAAA_5555, 6'h09, 6'h05);
    idle(6'h09, 6'h09);
    idle(6'h09, 6'h09);

    // Capture immediately followed by a stalled cycle still commits
    step(1'b1, 1'b1, 1'b0, 2'b10, 5'd9, 32'h0BAD_F00D, 6'h29, 6'h09);
    step(1'b1, 1'b1, 1'b1, 2'b10, 5'd9, 32'h1111_1111, 6'h29, 6'h09);
    idle(6'h29, 6'h09);

    // Back-to-back writes to GPR[7] after a fresh reset
    step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 6'h07, 6'h07);
    step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 6'h07, 6'h07);
    step(1'b1, 1'b1, 1'b0, 2'b01, 5'd7, 32'h1, 6'h07, 6'h07);
    step(1'b1, 1'b1, 1'b0, 2'b01, 5'd7, 32'h2, 6'h07, 6'h07);
    step(1'b1, 1'b1, 1'b0, 2'b11, 5'd7, 32'h3, 6'h07, 6'h27);
    repeat (3) idle(6'h07, 6'h27);

    // Randomized traffic over a small register pool to provoke collisions
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 9) == 0) ? 5'd29 : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0),
           2'($urandom),
           rd,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           {1'($urandom), ($urandom_range(0, 9) == 0) ? 5'd29 : 5'($urandom_range(0, 7))},
           {1'($urandom), 5'($urandom_range(0, 7))});
    end
    idle(6'h00, 6'h20);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage after `execute`, with both register files. It captures each retiring result into the E/W pipeline register and drives `ew_d`/`ew_rw`/`ew_rd` back to `execute` for forwarding. It commits the result to the integer (GPR) or float (FPR) register file one cycle later. It also serves the two operand read ports used by decode, with bypass of the pending commit, and counts retired instructions.

## Interface
Parameters:
- `SP_REG`, default 29: GPR index initialised to `SP_INIT` on reset.
- `SP_INIT`, default 32'h0001_0000: stack pointer reset value.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `ex_d` in 32: result from execute.
- `ex_rw` in 2: destination file select. 00 none, 01 GPR, 10 FPR, 11 none.
- `ex_rd` in 5: destination index.
- `ex_valid` in 1: an instruction retires this cycle.
- `stall` in 1: execute busy (`uart_state`); blocks capture.
- `ew_d` out 32: registered result.
- `ew_rw` out 2: registered file select.
- `ew_rd` out 5: registered destination index.
- `rs_addr` in 6: read address A. Bit 5 = 1 selects FPR, bits 4:0 give the index.
- `rt_addr` in 6: read address B, same encoding.
- `rs_data` out 32: combinational read A.
- `rt_data` out 32: combinational read B.
- `retired` out 32: count of retired instructions.

## Operation
- Capture:
  - Condition: `ex_valid && !stall` at a rising edge.
  - Action: `ew_d`/`ew_rw`/`ew_rd` load `ex_*`, internal `ew_fresh` is set, and `retired` increments, wrapping at 2^32.
  - `retired` increments for every capture, including `ew_rw` = 00/11.
- No capture: `ew_*` hold their values, so forwarding stays valid through stalls, and `ew_fresh` clears.
  - `ex_valid` asserted during `stall` is ignored; execute re-presents the instruction afterwards.
- Commit:
  - Condition: at the edge after a capture, when `ew_fresh` is set.
  - `ew_rw`=01 writes GPR[`ew_rd`]; `ew_rw`=10 writes FPR[`ew_rd`]; 00/11 write nothing.
  - Writes to GPR[0] are discarded; GPR[0] always reads 0. FPR[0] is an ordinary register.
  - Each capture commits exactly once, even when `ew_*` is held.
- Read:
  - `rs_data`/`rt_data` select the file by address bit 5.
  - Bypass: if `ew_fresh` is set and the address matches the pending target (same file, same index, and not GPR[0]), the port returns `ew_d`; otherwise it returns the array content.
- Reset:
  - `ew_d`=0, `ew_rw`=00, `ew_rd`=0, `ew_fresh`=0, `retired`=0.
  - All GPR/FPR = 0, except GPR[`SP_REG`] = `SP_INIT`.
  - A pending commit is dropped.

## Timing
- A capture at edge N makes `ew_*` visible from cycle N.
- The same value enters the array at edge N+1.
- Reads of the target return the new value from cycle N onward: via bypass in cycle N, from the array from N+1.
- Back-to-back captures to the same register: the later capture wins, because the bypass always reflects the newest `ew_*`.
- Stall asserted in the cycle after a capture: the commit still occurs at N+1; only further captures are blocked.
- Read ports have zero latency (combinational). Both ports may address the same register.

## Structure
- Add RW_NONE=2'b00, RW_GPR=2'b01 and RW_FPR=2'b10 to the `constant` package. `execute` and decode use the same encoding.
- Sub-module `regfile32`:
  - 32×32 array, two combinational read ports, one synchronous write port.
  - Parameter `ZERO_R0` hardwires entry 0 to zero.
  - Reset-init parameters for one entry (`INIT_IDX`, `INIT_VAL`).
  - Instantiated twice: GPR with `ZERO_R0`=1, FPR with `ZERO_R0`=0.
- Top level holds the E/W register, `ew_fresh`, the bypass muxes and the `retired` counter.

## Test plan
- Reset: after `rstn` low for 2 cycles, `ew_*`=0 and `retired`=0; `rs_addr`=6'h1D reads 32'h0001_0000; `rs_addr`=6'h05 and 6'h25 read 0.
- GPR write: `ex_valid`=1, `ex_rw`=01, `ex_rd`=5, `ex_d`=32'h1234_5678 for one cycle.
  - Cycle after: `ew_d`=32'h1234_5678, and `rs_addr`=6'h05 reads it via bypass.
  - Two cycles after: same read from the array; `retired`=1.
- GPR[0] write of 32'hFFFF_FFFF: `rs_addr`=0 reads 0 in every cycle; `retired` still increments.
- FPR[3] write of 32'h3F80_0000: `rt_addr`=6'h23 reads 32'h3F80_0000 while `rs_addr`=6'h03 reads 0.
- Stall: `ex_valid`=1 with `stall`=1 for 3 cycles leaves `ew_*` and `retired` unchanged. Dropping `stall` captures exactly once and `retired` increases by 1.
- Back-to-back: writes to GPR[7] of values 1 then 2 on consecutive cycles, then a capture with `ex_rw`=11 and `ex_rd`=7.
  - `rs_addr`=6'h07 reads 2 in every subsequent cycle.
  - `retired`=3.
